// File: rtl/freq_range_autoscale.sv
// Two-range frequency front end: pass-through or divide-by-DIV_HIGH output, with
// forced or count-driven automatic range selection and a per-window edge count.
module freq_range_autoscale #(
    parameter int DIV_HIGH    = 10,
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int TH_UP       = 400,
    parameter int TH_DOWN     = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sigIn,
    input  logic [1:0]       modeControl,
    output logic             sigOut,
    output logic             rangeHigh,
    output logic [CNT_W-1:0] edgeCount,
    output logic             countValid,
    output logic             overflow
);

    localparam int HALF   = DIV_HIGH / 2;
    localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [31:0]       TH_UP_C   = 32'(TH_UP);
    localparam logic [31:0]       TH_DOWN_C = 32'(TH_DOWN);

    // Saturating increment; MSB of the result flags an increment attempted at full scale.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] value, input logic inc);
        if (inc && (value == CNT_MAX)) begin
            sat_inc = {1'b1, CNT_MAX};
        end else if (inc) begin
            sat_inc = {1'b0, value + CNT_W'(1'b1)};
        end else begin
            sat_inc = {1'b0, value};
        end
    endfunction

    logic              sync1_r, sync2_r, sync3_r;
    logic              rise_pulse_s;
    logic [GATE_W-1:0] gate_cnt_r;
    logic              window_close_s;
    logic [CNT_W-1:0]  edge_acc_r;
    logic              ovf_acc_r;
    logic [CNT_W:0]    acc_inc_s;
    logic [CNT_W-1:0]  acc_next_s;
    logic              ovf_next_s;
    logic              range_next_s;
    logic              range_change_s;
    logic [HALF_W-1:0] half_cnt_r, half_next_s;
    logic              toggle_r, toggle_next_s;
    logic              sig_out_r, range_high_r, count_valid_r, overflow_r;
    logic [CNT_W-1:0]  edge_count_r;

    assign rise_pulse_s   = sync2_r & ~sync3_r;
    assign window_close_s = (gate_cnt_r == GATE_LAST);
    assign acc_inc_s      = sat_inc(edge_acc_r, rise_pulse_s);
    assign acc_next_s     = acc_inc_s[CNT_W-1:0];
    assign ovf_next_s     = ovf_acc_r | acc_inc_s[CNT_W];
    assign range_change_s = range_next_s ^ range_high_r;

    assign sigOut     = sig_out_r;
    assign rangeHigh  = range_high_r;
    assign edgeCount  = edge_count_r;
    assign countValid = count_valid_r;
    assign overflow   = overflow_r;

    // Three-flop synchroniser for the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= sigIn;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Range decision; auto mode only moves at window close, using the closing count.
    always_comb begin
        range_next_s = range_high_r;
        case (modeControl)
            2'b00:   range_next_s = 1'b0;
            2'b01:   range_next_s = 1'b1;
            default: begin
                if (window_close_s && (32'(acc_next_s) > TH_UP_C)) begin
                    range_next_s = 1'b1;
                end else if (window_close_s && (32'(acc_next_s) < TH_DOWN_C)) begin
                    range_next_s = 1'b0;
                end else begin
                    range_next_s = range_high_r;
                end
            end
        endcase
    end

    // Divider: toggle every DIV_HIGH/2 synced rises; any range change restarts it low.
    always_comb begin
        half_next_s   = half_cnt_r;
        toggle_next_s = toggle_r;
        if (range_change_s) begin
            half_next_s   = {HALF_W{1'b0}};
            toggle_next_s = 1'b0;
        end else if (range_high_r && rise_pulse_s) begin
            if (half_cnt_r == HALF_LAST) begin
                half_next_s   = {HALF_W{1'b0}};
                toggle_next_s = ~toggle_r;
            end else begin
                half_next_s   = half_cnt_r + HALF_W'(1'b1);
                toggle_next_s = toggle_r;
            end
        end else begin
            half_next_s   = half_cnt_r;
            toggle_next_s = toggle_r;
        end
    end

    // Range, divider state and the output mux register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_high_r <= 1'b0;
            half_cnt_r   <= {HALF_W{1'b0}};
            toggle_r     <= 1'b0;
            sig_out_r    <= 1'b0;
        end else begin
            range_high_r <= range_next_s;
            half_cnt_r   <= half_next_s;
            toggle_r     <= toggle_next_s;
            sig_out_r    <= range_next_s ? toggle_next_s : sync2_r;
        end
    end

    // Gate window, edge accumulation and the published per-window result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt_r    <= {GATE_W{1'b0}};
            edge_acc_r    <= {CNT_W{1'b0}};
            ovf_acc_r     <= 1'b0;
            edge_count_r  <= {CNT_W{1'b0}};
            overflow_r    <= 1'b0;
            count_valid_r <= 1'b0;
        end else if (window_close_s) begin
            gate_cnt_r    <= {GATE_W{1'b0}};
            edge_acc_r    <= {CNT_W{1'b0}};
            ovf_acc_r     <= 1'b0;
            edge_count_r  <= acc_next_s;
            overflow_r    <= ovf_next_s;
            count_valid_r <= 1'b1;
        end else begin
            gate_cnt_r    <= gate_cnt_r + GATE_W'(1'b1);
            edge_acc_r    <= acc_next_s;
            ovf_acc_r     <= ovf_next_s;
            count_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_range_autoscale.sv
// Directed bench for freq_range_autoscale: window results go through a scoreboard
// queue; waveform, latency and reset behaviour are checked inline.
module tb_freq_range_autoscale;

    logic        clk;
    logic        rst;
    logic        sig_in;
    logic [1:0]  mode_control;
    logic        sig_out, range_high, count_valid, overflow;
    logic [15:0] edge_count;
    logic        b_sig_out, b_range_high, b_count_valid, b_overflow;
    logic [7:0]  b_edge_count;

    int   period = 0;
    int   ph = 0;
    logic manual_level = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    typedef struct {
        bit chk_cnt;
        bit chk_rng;
        int cnt;
        bit ovf;
        bit rng;
        int b_cnt;
        bit b_ovf;
        bit b_rng;
    } exp_t;

    exp_t sb[$];

    freq_range_autoscale dut (
        .clk(clk), .rst(rst), .sigIn(sig_in), .modeControl(mode_control),
        .sigOut(sig_out), .rangeHigh(range_high), .edgeCount(edge_count),
        .countValid(count_valid), .overflow(overflow)
    );

    freq_range_autoscale #(.CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .sigIn(sig_in), .modeControl(mode_control),
        .sigOut(b_sig_out), .rangeHigh(b_range_high), .edgeCount(b_edge_count),
        .countValid(b_count_valid), .overflow(b_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Input generator: periodic when period != 0, otherwise the manual level.
    initial begin
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (period != 0) begin
                sig_in = (ph < period / 2);
                ph = (ph + 1 >= period) ? 0 : ph + 1;
            end else begin
                sig_in = manual_level;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input bit chk_cnt, input bit chk_rng, input int cnt, input bit ovf,
                            input bit rng, input int b_cnt, input bit b_ovf, input bit b_rng);
        exp_t e;
        e.chk_cnt = chk_cnt; e.chk_rng = chk_rng;
        e.cnt = cnt; e.ovf = ovf; e.rng = rng;
        e.b_cnt = b_cnt; e.b_ovf = b_ovf; e.b_rng = b_rng;
        sb.push_back(e);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!count_valid && n < 1100);
        check("valid_timeout", 32'(count_valid), 32'd1);
    endtask

    // Scoreboard consumer and countValid pulse-width monitor.
    initial begin
        exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_valid) check("valid_one_cycle", 32'(count_valid), 32'd0);
            prev_valid = count_valid;
            if (count_valid) begin
                check("b_valid_aligned", 32'(b_count_valid), 32'd1);
                if (sb.size() == 0) begin
                    check("sb_unexpected_valid", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    if (e.chk_cnt) begin
                        check("edge_count", 32'(edge_count), 32'(e.cnt));
                        check("overflow", 32'(overflow), 32'(e.ovf));
                        check("b_edge_count", 32'(b_edge_count), 32'(e.b_cnt));
                        check("b_overflow", 32'(b_overflow), 32'(e.b_ovf));
                    end
                    if (e.chk_rng) begin
                        check("range_high", 32'(range_high), 32'(e.rng));
                        check("b_range_high", 32'(b_range_high), 32'(e.b_rng));
                    end
                end
            end
        end
    end

    initial begin
        int   n, hi, lo, bad;
        logic prev, rise;
        logic hist [0:299];

        rst = 1'b1;
        mode_control = 2'b00;
        repeat (3) step();
        check("rst_sig_out", 32'(sig_out), 32'd0);
        check("rst_range_high", 32'(range_high), 32'd0);
        check("rst_edge_count", 32'(edge_count), 32'd0);
        check("rst_count_valid", 32'(count_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Idle window straight after reset release
        push_exp(1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        wait_valid(n);
        check("first_valid_latency", 32'(n), 32'd1000);

        // Forced low, period 100: output is input delayed by three edges
        period = 100;
        push_exp(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            hist[i] = sig_in;
            if (i >= 3 && sig_out !== hist[i-3]) bad++;
        end
        check("low_passthrough_errors", 32'(bad), 32'd0);
        check("low_range_high", 32'(range_high), 32'd0);
        wait_valid(n);
        push_exp(1'b1, 1'b1, 10, 1'b0, 1'b0, 10, 1'b0, 1'b0);
        wait_valid(n);

        // Forced high, period 20: first output rise on 5th counted rise, then 100/100
        period = 20;
        push_exp(1'b0, 1'b1, 0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        prev = sig_in;
        n = 0;
        do begin
            step();
            rise = sig_in && !prev;
            prev = sig_in;
            n++;
        end while (!rise && n < 100);
        check("align_rise_found", 32'(rise), 32'd1);
        step();
        mode_control = 2'b01;
        n = 1;
        while (n < 300) begin
            step();
            n++;
            if (sig_out) break;
        end
        check("high_first_rise", 32'(n), 32'd83);
        hi = 0;
        while (sig_out && hi < 300) begin step(); hi++; end
        check("high_duty_high", 32'(hi), 32'd100);
        lo = 0;
        while (!sig_out && lo < 300) begin step(); lo++; end
        check("high_duty_low", 32'(lo), 32'd100);
        wait_valid(n);
        push_exp(1'b1, 1'b1, 50, 1'b0, 1'b1, 50, 1'b0, 1'b1);
        wait_valid(n);

        // Forced low at period 2, then auto: A goes high on 500, B saturates and holds low
        mode_control = 2'b00;
        period = 2;
        push_exp(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        wait_valid(n);
        mode_control = 2'b10;
        push_exp(1'b1, 1'b1, 500, 1'b0, 1'b1, 255, 1'b1, 1'b0);
        repeat (500) step();
        check("auto_entry_hold", 32'(range_high), 32'd0);
        wait_valid(n);

        // Hysteresis: count 50 holds, count 20 drops
        period = 20;
        push_exp(1'b0, 1'b1, 0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        wait_valid(n);
        push_exp(1'b1, 1'b1, 50, 1'b0, 1'b1, 50, 1'b0, 1'b0);
        wait_valid(n);
        period = 50;
        push_exp(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        wait_valid(n);
        push_exp(1'b1, 1'b1, 20, 1'b0, 1'b0, 20, 1'b0, 1'b0);
        wait_valid(n);

        // Boundary: a rise whose pulse lands on the final gate cycle
        period = 0;
        manual_level = 1'b0;
        push_exp(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        wait_valid(n);
        push_exp(1'b1, 1'b1, 4, 1'b0, 1'b0, 4, 1'b0, 1'b0);
        for (int j = 1; j <= 996; j++) begin
            step();
            if (j == 10 || j == 50 || j == 100 || j == 996) manual_level = 1'b1;
            if (j == 15 || j == 55 || j == 105) manual_level = 1'b0;
        end
        wait_valid(n);
        check("boundary_close_latency", 32'(n), 32'd4);
        push_exp(1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        repeat (20) step();
        manual_level = 1'b0;
        wait_valid(n);

        // Forced high at period 20, then async reset while the output is high
        mode_control = 2'b01;
        period = 20;
        push_exp(1'b0, 1'b1, 0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        wait_valid(n);
        push_exp(1'b1, 1'b1, 50, 1'b0, 1'b1, 50, 1'b0, 1'b1);
        wait_valid(n);
        n = 0;
        while (!sig_out && n < 400) begin step(); n++; end
        check("sig_out_high_before_rst", 32'(sig_out), 32'd1);
        rst = 1'b1;
        #1;
        check("async_sig_out", 32'(sig_out), 32'd0);
        check("async_range_high", 32'(range_high), 32'd0);
        check("async_edge_count", 32'(edge_count), 32'd0);
        check("async_count_valid", 32'(count_valid), 32'd0);
        check("async_overflow", 32'(overflow), 32'd0);
        sb.delete();
        prev = sig_in;
        n = 0;
        do begin
            step();
            rise = sig_in && !prev;
            prev = sig_in;
            n++;
        end while (!rise && n < 100);
        check("rst_align_rise_found", 32'(rise), 32'd1);
        push_exp(1'b1, 1'b1, 50, 1'b0, 1'b1, 50, 1'b0, 1'b1);
        rst = 1'b0;
        wait_valid(n);
        check("post_rst_valid_latency", 32'(n), 32'd1000);
        repeat (2) step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
